// File: rtl/wb_timer.sv
// wb_timer: Wishbone-slave programmable interval timer with a level interrupt and iack clear.
// Optional: define WB_TIMER_MISSED_EN to add the saturating MISSED-expiry counter at address 4.
module wb_timer #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dat_i,
  input  logic [31:0] adr_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        timer_irq,
  input  logic        timer_iack
);

  logic             ack_reg, irq_reg;
  logic [31:0]      dat_reg, rd_data;
  logic             en_reg, en_next, reload_reg, reload_next, ie_reg, ie_next;
  logic             exp_reg, exp_next;
  logic [PRE_W-1:0] pre_reg, pre_next, presc_reg, presc_next;
  logic [CNT_W-1:0] load_reg, load_next, count_reg, count_next;
  logic [31:0]      byte_mask, ctrl_cur, ctrl_wdata, load_cur, load_wdata;
  logic [2:0]       reg_sel;
  logic             access, wr, wr_ctrl, wr_load, wr_status, tick, expire, status_clr;
  logic             unused_bits;

`ifdef WB_TIMER_MISSED_EN
  logic [7:0] missed_reg;
  logic       wr_missed;
  assign wr_missed = wr && (reg_sel == 3'd4);
`endif

  // A transfer is serviced only on the first strobe cycle, so a long strobe never repeats a write.
  assign access    = stb_i & ~ack_reg;
  assign wr        = access & we_i;
  assign reg_sel   = adr_i[4:2];
  assign wr_ctrl   = wr && (reg_sel == 3'd0);
  assign wr_load   = wr && (reg_sel == 3'd1);
  assign wr_status = wr && (reg_sel == 3'd3);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_mask[gi*8 +: 8] = {8{sel_i[gi]}};
    end
  endgenerate

  always_comb begin
    ctrl_cur              = '0;
    ctrl_cur[2:0]         = {ie_reg, reload_reg, en_reg};
    ctrl_cur[16 +: PRE_W] = pre_reg;
    load_cur              = '0;
    load_cur[CNT_W-1:0]   = load_reg;
  end

  assign ctrl_wdata  = (ctrl_cur & ~byte_mask) | (dat_i & byte_mask);
  assign load_wdata  = (load_cur & ~byte_mask) | (dat_i & byte_mask);
  assign unused_bits = ^{adr_i[31:5], adr_i[1:0], ctrl_wdata, load_wdata};

  assign tick       = en_reg && (presc_reg == pre_reg);
  assign expire     = tick && (count_reg == '0);
  assign status_clr = timer_iack || (wr_status && sel_i[0] && dat_i[0]);

  always_comb begin
    en_next     = en_reg;
    reload_next = reload_reg;
    ie_next     = ie_reg;
    pre_next    = pre_reg;
    presc_next  = presc_reg;
    load_next   = load_reg;
    count_next  = count_reg;
    exp_next    = exp_reg;

    if (en_reg) presc_next = tick ? '0 : presc_reg + PRE_W'(1);

    if (tick) begin
      if (count_reg != '0) count_next = count_reg - CNT_W'(1);
      else if (reload_reg) count_next = load_reg;
      else                 en_next    = 1'b0;
    end

    if (wr_ctrl) begin
      en_next     = ctrl_wdata[0];
      reload_next = ctrl_wdata[1];
      ie_next     = ctrl_wdata[2];
      pre_next    = ctrl_wdata[16 +: PRE_W];
      // Only a 0->1 transition of EN restarts the count from LOAD.
      if (ctrl_wdata[0] && !en_reg) begin
        count_next = load_reg;
        presc_next = '0;
      end
    end

    if (wr_load) load_next = load_wdata[CNT_W-1:0];

    // A same-cycle expiry beats any clear.
    if (status_clr) exp_next = 1'b0;
    if (expire)     exp_next = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd0: rd_data = ctrl_cur;
      3'd1: rd_data[CNT_W-1:0] = load_reg;
      3'd2: rd_data[CNT_W-1:0] = count_reg;
      3'd3: rd_data[0] = exp_reg;
`ifdef WB_TIMER_MISSED_EN
      3'd4: rd_data[7:0] = missed_reg;
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      irq_reg    <= 1'b0;
      en_reg     <= 1'b0;
      reload_reg <= 1'b0;
      ie_reg     <= 1'b0;
      pre_reg    <= '0;
      presc_reg  <= '0;
      load_reg   <= '0;
      count_reg  <= '0;
      exp_reg    <= 1'b0;
    end else begin
      ack_reg <= stb_i;
      if (access)      dat_reg <= rd_data;
      else if (!stb_i) dat_reg <= '0;
      irq_reg    <= exp_reg & ie_reg;
      en_reg     <= en_next;
      reload_reg <= reload_next;
      ie_reg     <= ie_next;
      pre_reg    <= pre_next;
      presc_reg  <= presc_next;
      load_reg   <= load_next;
      count_reg  <= count_next;
      exp_reg    <= exp_next;
    end
  end

`ifdef WB_TIMER_MISSED_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                        missed_reg <= '0;
    else if (wr_missed)                               missed_reg <= '0;
    else if (expire && exp_reg && missed_reg != 8'hFF) missed_reg <= missed_reg + 8'd1;
  end
`endif

  assign dat_o     = dat_reg;
  assign ack_o     = ack_reg;
  assign timer_irq = irq_reg;

endmodule
